// File: rtl/mem_port_arbiter.sv
// Arbitrates one registered memory port between IF and LS requesters; one access in flight.
// Define MEM_ARB_RR_EN for round-robin arbitration; the default is fixed priority with LS first.
module mem_port_arbiter #(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned MEM_LAT = 1
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic                i_if_req,
    input  logic [ADDR_W-1:0]   i_if_addr,
    output logic                o_if_gnt,
    output logic                o_if_rvalid,
    output logic [DATA_W-1:0]   o_if_rdata,
    input  logic                i_ls_req,
    input  logic                i_ls_we,
    input  logic [DATA_W/8-1:0] i_ls_be,
    input  logic [ADDR_W-1:0]   i_ls_addr,
    input  logic [DATA_W-1:0]   i_ls_wdata,
    output logic                o_ls_gnt,
    output logic                o_ls_rvalid,
    output logic [DATA_W-1:0]   o_ls_rdata,
    output logic [ADDR_W-1:0]   o_mem_addr,
    output logic                o_mem_we,
    output logic [DATA_W/8-1:0] o_mem_be,
    output logic [DATA_W-1:0]   o_mem_wdata,
    input  logic [DATA_W-1:0]   i_mem_rdata,
    output logic                o_busy
);

    localparam int unsigned BeW     = DATA_W / 8;
    localparam logic [2:0]  LastCnt = 3'(MEM_LAT - 1);

    typedef enum logic [1:0] {StIdle, StAccess, StWait, StResp} state_e;

    state_e              state_q, state_d;
    logic [2:0]          cnt_q, cnt_d;
    logic                owner_ls_q, owner_ls_d;
    logic                is_wr_q, is_wr_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic                we_q, we_d;
    logic [BeW-1:0]      be_q, be_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [DATA_W-1:0]   if_rdata_q, if_rdata_d;
    logic [DATA_W-1:0]   ls_rdata_q, ls_rdata_d;
    logic                idle, ls_win, if_win;

    // Grants are suppressed while reset is asserted so every output reads 0.
    assign idle = (state_q == StIdle) && i_rst_n;

`ifdef MEM_ARB_RR_EN
    logic rr_q, rr_d;  // last grantee: 1 = LS, 0 = IF

    assign ls_win = idle && i_ls_req && (!i_if_req || !rr_q);
    assign if_win = idle && i_if_req && (!i_ls_req || rr_q);
    assign rr_d   = ls_win ? 1'b1 : (if_win ? 1'b0 : rr_q);

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) rr_q <= 1'b0;
        else          rr_q <= rr_d;
    end
`else
    assign ls_win = idle && i_ls_req;
    assign if_win = idle && i_if_req && !i_ls_req;
`endif

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        owner_ls_d = owner_ls_q;
        is_wr_d    = is_wr_q;
        addr_d     = addr_q;
        we_d       = 1'b0;
        be_d       = '0;
        wdata_d    = wdata_q;
        if_rdata_d = if_rdata_q;
        ls_rdata_d = ls_rdata_q;
        case (state_q)
            StIdle: begin
                if (ls_win) begin
                    state_d    = StAccess;
                    owner_ls_d = 1'b1;
                    is_wr_d    = i_ls_we;
                    addr_d     = i_ls_addr;
                    wdata_d    = i_ls_wdata;
                    we_d       = i_ls_we;
                    be_d       = i_ls_we ? i_ls_be : '0;
                end else if (if_win) begin
                    state_d    = StAccess;
                    owner_ls_d = 1'b0;
                    is_wr_d    = 1'b0;
                    addr_d     = i_if_addr;
                end
            end
            StAccess: begin
                cnt_d   = '0;
                state_d = is_wr_q ? StResp : StWait;
            end
            StWait: begin
                // Read data is valid during the last wait cycle; capture it at its end.
                if (cnt_q == LastCnt) begin
                    state_d = StResp;
                    if (owner_ls_q) ls_rdata_d = i_mem_rdata;
                    else            if_rdata_d = i_mem_rdata;
                end else begin
                    cnt_d = cnt_q + 3'd1;
                end
            end
            StResp:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            owner_ls_q <= 1'b0;
            is_wr_q    <= 1'b0;
            addr_q     <= '0;
            we_q       <= 1'b0;
            be_q       <= '0;
            wdata_q    <= '0;
            if_rdata_q <= '0;
            ls_rdata_q <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            owner_ls_q <= owner_ls_d;
            is_wr_q    <= is_wr_d;
            addr_q     <= addr_d;
            we_q       <= we_d;
            be_q       <= be_d;
            wdata_q    <= wdata_d;
            if_rdata_q <= if_rdata_d;
            ls_rdata_q <= ls_rdata_d;
        end
    end

    assign o_if_gnt    = if_win;
    assign o_ls_gnt    = ls_win;
    assign o_if_rvalid = (state_q == StResp) && !owner_ls_q;
    assign o_ls_rvalid = (state_q == StResp) && owner_ls_q;
    assign o_if_rdata  = if_rdata_q;
    assign o_ls_rdata  = ls_rdata_q;
    assign o_mem_addr  = addr_q;
    assign o_mem_we    = we_q;
    assign o_mem_be    = be_q;
    assign o_mem_wdata = wdata_q;
    assign o_busy      = (state_q != StIdle);

endmodule
